// File: rtl/uop_fetch_seq.sv
// Micro-op fetch sequencer: walks the micro-op ROM from an entry point and
// hands each fetched micro-op downstream on a valid/ready handshake.
module uop_fetch_seq #(
   parameter logic [7:0]  TERM    = 8'h00,
   parameter int unsigned MAX_LEN = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] start_addr,
   output logic [7:0] rom_add,
   output logic       rom_cs,
   output logic       rom_cen,
   input  logic [7:0] rom_uop,
   output logic [7:0] uop_out,
   output logic       uop_valid,
   input  logic       uop_ready,
   output logic       busy,
   output logic       done,
   output logic       trunc,
   output logic [8:0] count
);

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 9;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR   = 3'd1,
      STROBE = 3'd2,
      CAPT   = 3'd3,
      OUT    = 3'd4
   } state_t;

   state_t        state;
   state_t        state_d;
   logic [AW-1:0] rom_add_d;
   logic          rom_cs_d;
   logic [DW-1:0] uop_out_d;
   logic          uop_valid_d;
   logic          busy_d;
   logic          done_d;
   logic          trunc_d;
   logic [CW-1:0] count_d;

   // Next-state and next-output decode; every register value is computed here.
   always_comb begin
      state_d     = state;
      rom_add_d   = rom_add;
      uop_out_d   = uop_out;
      uop_valid_d = uop_valid;
      done_d      = 1'b0;
      trunc_d     = trunc;
      count_d     = count;
      rom_cs_d    = 1'b0;
      busy_d      = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               rom_add_d = start_addr;
               count_d   = '0;
               trunc_d   = 1'b0;
               state_d   = ADDR;
            end
         end
         ADDR:   state_d = STROBE;
         STROBE: state_d = CAPT;
         CAPT: begin
            if (rom_uop == TERM) begin
               done_d  = 1'b1;
               trunc_d = 1'b0;
               state_d = IDLE;
            end else begin
               uop_out_d   = rom_uop;
               uop_valid_d = 1'b1;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (uop_ready) begin
               count_d     = count + CW'(1);
               uop_valid_d = 1'b0;
               // Address space never wraps: 255 is the last fetch of any sequence.
               if ((count_d == CW'(MAX_LEN)) || (rom_add == {AW{1'b1}})) begin
                  done_d  = 1'b1;
                  trunc_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  rom_add_d = rom_add + AW'(1);
                  state_d   = ADDR;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Strobe is high exactly for the STROBE cycle; busy mirrors the next state.
      rom_cs_d = (state_d == STROBE);
      busy_d   = (state_d != IDLE);
   end

   // State and output registers with synchronous reset; rom_cen low only in reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rom_add   <= '0;
         rom_cs    <= 1'b0;
         rom_cen   <= 1'b0;
         uop_out   <= '0;
         uop_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         trunc     <= 1'b0;
         count     <= '0;
      end else begin
         state     <= state_d;
         rom_add   <= rom_add_d;
         rom_cs    <= rom_cs_d;
         rom_cen   <= 1'b1;
         uop_out   <= uop_out_d;
         uop_valid <= uop_valid_d;
         busy      <= busy_d;
         done      <= done_d;
         trunc     <= trunc_d;
         count     <= count_d;
      end
   end

endmodule

// File: tb/tb_uop_fetch_seq.sv
// Directed bench for uop_fetch_seq with a behavioural micro-op ROM model.
module tb_uop_fetch_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] start_addr;
   logic [7:0] rom_add;
   logic       rom_cs;
   logic       rom_cen;
   logic [7:0] rom_uop;
   logic [7:0] uop_out;
   logic       uop_valid;
   logic       uop_ready;
   logic       busy;
   logic       done;
   logic       trunc;
   logic [8:0] count;

   logic [7:0] mem [256];

   int total = 0;
   int bad   = 0;
   int cyc;
   int ncs;
   int first_valid;
   logic [7:0] acc [$];

   always #5 clk = ~clk;

   uop_fetch_seq #(.TERM(8'h00), .MAX_LEN(4)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .rom_add    (rom_add),
      .rom_cs     (rom_cs),
      .rom_cen    (rom_cen),
      .rom_uop    (rom_uop),
      .uop_out    (uop_out),
      .uop_valid  (uop_valid),
      .uop_ready  (uop_ready),
      .busy       (busy),
      .done       (done),
      .trunc      (trunc),
      .count      (count)
   );

   // ROM: output register loads on rising chip-select, cleared while cen is low.
   always @(posedge rom_cs or negedge rom_cen) begin
      if (!rom_cen) rom_uop <= 8'h00;
      else          rom_uop <= mem[rom_add];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock: record accepted micro-op, strobe count and first valid cycle.
   task automatic step();
      if (uop_valid && uop_ready) acc.push_back(uop_out);
      tick();
      cyc++;
      if (rom_cs) ncs++;
      if (uop_valid && first_valid < 0) first_valid = cyc;
   endtask

   task automatic start_seq(input logic [7:0] a);
      start = 1'b1;
      start_addr = a;
      tick();
      start = 1'b0;
      cyc = 0;
      ncs = 0;
      first_valid = -1;
      acc.delete();
      check("start_busy", busy, 1);
      check("start_addr", rom_add, a);
      check("start_count_clr", count, 0);
   endtask

   task automatic finish_seq(input int maxc);
      while (!done && cyc < maxc) step();
      check("done_timeout", done, 1);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      start_addr = 8'h00;
      uop_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h02;
      mem[0]  = 8'h00;
      mem[10] = 8'h21;
      mem[11] = 8'h22;
      mem[12] = 8'h23;
      mem[13] = 8'h00;
      tick();
      tick();

      // Reset values
      check("rst_rom_add", rom_add, 0);
      check("rst_rom_cs", rom_cs, 0);
      check("rst_rom_cen", rom_cen, 0);
      check("rst_uop_out", uop_out, 0);
      check("rst_valid", uop_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_trunc", trunc, 0);
      check("rst_count", count, 0);
      rst = 1'b0;
      tick();
      check("cen_after_rst", rom_cen, 1);

      // Basic fetch with uop_ready high
      uop_ready = 1'b1;
      start_seq(8'd10);
      finish_seq(40);
      check("basic_first_valid", first_valid, 3);
      check("basic_done_cycle", cyc, 15);
      check("basic_nacc", acc.size(), 3);
      if (acc.size() == 3) begin
         check("basic_uop0", acc[0], 8'h21);
         check("basic_uop1", acc[1], 8'h22);
         check("basic_uop2", acc[2], 8'h23);
      end
      check("basic_cs_pulses", ncs, 4);
      check("basic_trunc", trunc, 0);
      check("basic_count", count, 3);
      check("basic_busy_at_done", busy, 0);
      step();
      check("basic_done_one_cycle", done, 0);
      check("basic_count_hold", count, 3);

      // Backpressure on the first micro-op
      uop_ready = 1'b0;
      start_seq(8'd10);
      step(); step(); step();
      check("bp_valid", uop_valid, 1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold_uop", uop_out, 8'h21);
         check("bp_hold_valid", uop_valid, 1);
         check("bp_hold_addr", rom_add, 10);
         check("bp_no_cs", rom_cs, 0);
      end
      uop_ready = 1'b1;
      finish_seq(60);
      check("bp_nacc", acc.size(), 3);
      if (acc.size() == 3) begin
         check("bp_uop0", acc[0], 8'h21);
         check("bp_uop2", acc[2], 8'h23);
      end
      check("bp_cs_pulses", ncs, 4);
      check("bp_count", count, 3);
      check("bp_trunc", trunc, 0);

      // Immediate terminator
      start_seq(8'd0);
      finish_seq(20);
      check("term_done_cycle", cyc, 3);
      check("term_no_valid", first_valid, -1);
      check("term_count", count, 0);
      check("term_trunc", trunc, 0);

      // Length limit (MAX_LEN = 4)
      start_seq(8'd1);
      finish_seq(60);
      check("len_nacc", acc.size(), 4);
      foreach (acc[i]) check("len_uop", acc[i], 8'h02);
      check("len_trunc", trunc, 1);
      check("len_count", count, 4);
      check("len_last_addr", rom_add, 4);
      step();
      check("len_trunc_hold", trunc, 1);

      // Top of address space with a start pulsed while busy
      start_seq(8'd254);
      step();
      start = 1'b1;
      start_addr = 8'd5;
      step();
      start = 1'b0;
      finish_seq(40);
      check("top_nacc", acc.size(), 2);
      check("top_trunc", trunc, 1);
      check("top_count", count, 2);
      check("top_addr", rom_add, 255);
      step(); step();
      check("top_start_ignored", busy, 0);
      check("top_addr_hold", rom_add, 255);

      // Reset while a micro-op is pending in OUT
      uop_ready = 1'b0;
      start_seq(8'd10);
      step(); step(); step();
      check("rmid_valid_before", uop_valid, 1);
      rst = 1'b1;
      tick();
      check("rmid_valid", uop_valid, 0);
      check("rmid_busy", busy, 0);
      check("rmid_cen", rom_cen, 0);
      check("rmid_count", count, 0);
      check("rmid_no_done", done, 0);
      rst = 1'b0;
      tick();
      check("rmid_cen_back", rom_cen, 1);
      check("rmid_idle", busy, 0);
      check("rmid_done_quiet", done, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
